// File: rtl/pixel_collector_uart.sv
// Clamps signed conv results to 8-bit pixels and buffers them in a FWFT FIFO for the CPU.
// Optional statistics outputs are enabled with the PIXEL_COLLECTOR_STATS_EN macro.
module pixel_collector_uart #(
  parameter int unsigned RES_W  = 20,
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    res_valid,
  input  logic signed [RES_W-1:0] res_in,
  input  logic                    rd_en,
  input  logic                    clear,
  output logic                    rd_valid,
  output logic [7:0]              rd_data,
  output logic [ADDR_W:0]         level,
  output logic                    full,
  output logic                    overflow
`ifdef PIXEL_COLLECTOR_STATS_EN
  ,
  output logic [31:0]             rx_count,
  output logic [15:0]             drop_count,
  output logic                    sat_hit
`endif
);

  localparam int unsigned LVL_W = ADDR_W + 1;

  logic              stage_valid;
  logic [7:0]        stage_data;
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [LVL_W-1:0]  level_q;
  logic [7:0]        mem [DEPTH];

  logic              is_neg;
  logic              is_big;
  logic [7:0]        sat_c;
  logic              wr;
  logic              rd;
  logic              drop;
  logic [LVL_W-1:0]  level_nxt;

  // Signed saturation of the incoming sample to 0..255
  assign is_neg = res_in[RES_W-1];
  assign is_big = res_in > $signed(RES_W'(255));
  assign sat_c  = is_neg ? 8'h00 : (is_big ? 8'hFF : res_in[7:0]);

  assign rd_valid = (level_q != '0);
  assign full     = (level_q == LVL_W'(DEPTH));
  assign level    = level_q;
  assign rd_data  = rd_valid ? mem[rd_ptr] : 8'h00;

  // A pop in the same cycle frees the slot the staged sample needs
  assign rd   = rd_en & rd_valid;
  assign wr   = stage_valid & (~full | rd);
  assign drop = stage_valid & full & ~rd;

  always_comb begin
    level_nxt = level_q;
    case ({wr, rd})
      2'b10:   level_nxt = level_q + LVL_W'(1);
      2'b01:   level_nxt = level_q - LVL_W'(1);
      default: level_nxt = level_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stage_valid <= 1'b0;
      stage_data  <= 8'h00;
    end else if (clear) begin
      stage_valid <= 1'b0;
      stage_data  <= 8'h00;
    end else begin
      stage_valid <= res_valid;
      if (res_valid) stage_data <= sat_c;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level_q  <= '0;
      overflow <= 1'b0;
    end else if (clear) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level_q  <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr)   wr_ptr   <= wr_ptr + ADDR_W'(1);
      if (rd)   rd_ptr   <= rd_ptr + ADDR_W'(1);
      if (drop) overflow <= 1'b1;
      level_q <= level_nxt;
    end
  end

  // Storage array is intentionally left unreset
  always_ff @(posedge clk) begin
    if (wr && !clear) mem[wr_ptr] <= stage_data;
  end

`ifdef PIXEL_COLLECTOR_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_count   <= '0;
      drop_count <= '0;
      sat_hit    <= 1'b0;
    end else if (clear) begin
      rx_count   <= '0;
      drop_count <= '0;
      sat_hit    <= 1'b0;
    end else begin
      if (stage_valid && (rx_count != '1))  rx_count   <= rx_count + 32'(1);
      if (drop && (drop_count != '1))       drop_count <= drop_count + 16'(1);
      if (res_valid && (is_neg || is_big))  sat_hit    <= 1'b1;
    end
  end
`endif

endmodule
